// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tristate bus: one-hot driver enables,
// enforced turnaround gap between owners and a bounded hold time per owner.
module tristate_bus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int TURN_CYC = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 timeout
);

  localparam int              OW       = $clog2(N);
  localparam logic [7:0]      HOLD_MAX = 8'(MAX_HOLD);
  localparam logic [1:0]      TURN_MAX = 2'(TURN_CYC);
  localparam logic [OW-1:0]   LAST_RST = OW'(N - 1);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_q, last_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    hold_q, hold_d;
  logic [1:0]    turn_q, turn_d;

  logic [OW-1:0] sel, cand;
  logic          found;

  // Scan upward from the slot after the previous owner, wrapping at N.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand = OW'((int'(last_q) + i) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    // NOTE: every *_d gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    last_d    = last_q;
    hold_d    = hold_q;
    turn_d    = turn_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = OWN;
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          owner_d      = sel;
          last_d       = sel;
          hold_d       = 8'd1;
        end
      end
      OWN: begin
        // Release on a dropped request or when the hold budget is spent; still
        // requesting at that point means the release was forced.
        if (!req[owner_q] || hold_q == HOLD_MAX) begin
          state_d   = TURN;
          grant_d   = '0;
          owner_d   = '0;
          hold_d    = '0;
          turn_d    = 2'd1;
          timeout_d = req[owner_q];
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      TURN: begin
        if (turn_q >= TURN_MAX) begin
          state_d = IDLE;
          turn_d  = '0;
        end else begin
          turn_d = turn_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = |grant_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      last_q    <= LAST_RST;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
      turn_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
      turn_q    <= turn_d;
    end
  end

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Scoreboard bench: each step drives reset/req and queues the outputs expected
// after the next rising edge; a second instance covers a 3-cycle turnaround.
module tb_tristate_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] req2 = '0;
  logic [3:0] grant, grant2;
  logic [1:0] owner, owner2;
  logic       busy, busy2, timeout, timeout2;

  int checks = 0;
  int fails  = 0;
  int hold_run = 0;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       timeout;
  } step_t;

  step_t stim_q[$];
  step_t exp_q[$];

  tristate_bus_arbiter #(.N(4), .MAX_HOLD(8), .TURN_CYC(1)) dut (
    .clk(clk), .reset(reset), .req(req),
    .grant(grant), .owner(owner), .busy(busy), .timeout(timeout)
  );

  tristate_bus_arbiter #(.N(4), .MAX_HOLD(8), .TURN_CYC(3)) dut3 (
    .clk(clk), .reset(reset), .req(req2),
    .grant(grant2), .owner(owner2), .busy(busy2), .timeout(timeout2)
  );

  always #5 clk = ~clk;

  // Per-cycle invariants on both instances, plus the hold bound on the first.
  always @(negedge clk) begin
    hold_run = (grant != 4'b0) ? hold_run + 1 : 0;
    checks += 3;
    a_onehot: assert ($onehot0(grant) && $onehot0(grant2)) else begin
      fails++;
      $display("FAIL onehot0: grant=%b grant2=%b, required at most one bit set", grant, grant2);
    end
    a_busy: assert (busy === |grant && busy2 === |grant2) else begin
      fails++;
      $display("FAIL busy: busy=%b grant=%b busy2=%b grant2=%b, required busy == |grant", busy, grant, busy2, grant2);
    end
    a_hold: assert (hold_run <= 8) else begin
      fails++;
      $display("FAIL max_hold: grant held %0d cycles, required at most 8", hold_run);
    end
  end

  function automatic void add(input logic rst, input logic [3:0] r, input logic [3:0] g,
                              input logic [1:0] o, input logic t);
    stim_q.push_back('{rst: rst, req: r, grant: g, owner: o, timeout: t});
  endfunction

  task automatic test_reset_single();
    step_t s, e;
    int n = 0;
    add(1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    add(1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) add(0, 4'b0100, 4'b0100, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) add(0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset = s.rst; req = s.req;
      exp_q.push_back(s);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({grant, owner, busy, timeout} !== {e.grant, e.owner, |e.grant, e.timeout}) begin
        fails++;
        $display("FAIL reset_single step %0d: got grant=%b owner=%0d busy=%b timeout=%b, want grant=%b owner=%0d busy=%b timeout=%b",
                 n, grant, owner, busy, timeout, e.grant, e.owner, |e.grant, e.timeout);
      end
      n++;
    end
  endtask

  task automatic test_rotation();
    step_t s, e;
    int n = 0;
    logic [3:0] g;
    add(1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << (k % 4);
      for (int h = 0; h < 8; h++) add(0, 4'b1111, g, 2'(k % 4), 1'b0);
      if (k < 4) begin
        add(0, 4'b1111, 4'b0000, 2'd0, 1'b1);
        add(0, 4'b1111, 4'b0000, 2'd0, 1'b0);
      end
    end
    add(0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    add(0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset = s.rst; req = s.req;
      exp_q.push_back(s);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({grant, owner, busy, timeout} !== {e.grant, e.owner, |e.grant, e.timeout}) begin
        fails++;
        $display("FAIL rotation step %0d: got grant=%b owner=%0d busy=%b timeout=%b, want grant=%b owner=%0d busy=%b timeout=%b",
                 n, grant, owner, busy, timeout, e.grant, e.owner, |e.grant, e.timeout);
      end
      n++;
    end
  endtask

  task automatic test_wrap();
    step_t s, e;
    int n = 0;
    add(0, 4'b1000, 4'b1000, 2'd3, 1'b0);
    for (int i = 0; i < 7; i++) add(0, 4'b1001, 4'b1000, 2'd3, 1'b0);
    add(0, 4'b1001, 4'b0000, 2'd0, 1'b1);
    add(0, 4'b1001, 4'b0000, 2'd0, 1'b0);
    add(0, 4'b1001, 4'b0001, 2'd0, 1'b0);
    add(0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    add(0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset = s.rst; req = s.req;
      exp_q.push_back(s);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({grant, owner, busy, timeout} !== {e.grant, e.owner, |e.grant, e.timeout}) begin
        fails++;
        $display("FAIL wrap step %0d: got grant=%b owner=%0d busy=%b timeout=%b, want grant=%b owner=%0d busy=%b timeout=%b",
                 n, grant, owner, busy, timeout, e.grant, e.owner, |e.grant, e.timeout);
      end
      n++;
    end
  endtask

  task automatic test_no_preempt();
    step_t s, e;
    int n = 0;
    add(0, 4'b0010, 4'b0010, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) add(0, 4'b0011, 4'b0010, 2'd1, 1'b0);
    add(0, 4'b0001, 4'b0000, 2'd0, 1'b0);
    add(0, 4'b0001, 4'b0000, 2'd0, 1'b0);
    add(0, 4'b0001, 4'b0001, 2'd0, 1'b0);
    add(0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    add(0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset = s.rst; req = s.req;
      exp_q.push_back(s);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({grant, owner, busy, timeout} !== {e.grant, e.owner, |e.grant, e.timeout}) begin
        fails++;
        $display("FAIL no_preempt step %0d: got grant=%b owner=%0d busy=%b timeout=%b, want grant=%b owner=%0d busy=%b timeout=%b",
                 n, grant, owner, busy, timeout, e.grant, e.owner, |e.grant, e.timeout);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid();
    step_t s, e;
    int n = 0;
    add(0, 4'b0100, 4'b0100, 2'd2, 1'b0);
    add(0, 4'b0100, 4'b0100, 2'd2, 1'b0);
    add(1, 4'b0100, 4'b0000, 2'd0, 1'b0);
    add(0, 4'b0110, 4'b0010, 2'd1, 1'b0);
    add(0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    add(0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset = s.rst; req = s.req;
      exp_q.push_back(s);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({grant, owner, busy, timeout} !== {e.grant, e.owner, |e.grant, e.timeout}) begin
        fails++;
        $display("FAIL reset_mid step %0d: got grant=%b owner=%0d busy=%b timeout=%b, want grant=%b owner=%0d busy=%b timeout=%b",
                 n, grant, owner, busy, timeout, e.grant, e.owner, |e.grant, e.timeout);
      end
      n++;
    end
  endtask

  task automatic test_turn3();
    step_t s, e;
    int n = 0;
    add(1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    add(0, 4'b0011, 4'b0001, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) add(0, 4'b0010, 4'b0000, 2'd0, 1'b0);
    add(0, 4'b0010, 4'b0010, 2'd1, 1'b0);
    add(0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    req = 4'b0000;
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset = s.rst; req2 = s.req;
      exp_q.push_back(s);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({grant2, owner2, busy2, timeout2} !== {e.grant, e.owner, |e.grant, e.timeout}) begin
        fails++;
        $display("FAIL turn3 step %0d: got grant=%b owner=%0d busy=%b timeout=%b, want grant=%b owner=%0d busy=%b timeout=%b",
                 n, grant2, owner2, busy2, timeout2, e.grant, e.owner, |e.grant, e.timeout);
      end
      n++;
    end
  endtask

  initial begin
    test_reset_single();
    test_rotation();
    test_wrap();
    test_no_preempt();
    test_reset_mid();
    test_turn3();
    #1;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
